// File: rtl/segre_store_buffer.sv
// ---------------------------------------------------------------------------
// segre_store_buffer
//
// Purpose:
//   Small circular FIFO that holds committed stores between the TL stage and
//   the data cache.
//   - Stores enter in TL.
//   - The oldest entry drains to the dcache whenever MEM offers a free cache
//     slot (flush_chance_i).
//   - Loads in TL search the buffer combinationally for store-to-load
//     forwarding.
//   - A load that is only partly covered by the youngest overlapping store
//     reports trouble_o, so the core can stall until that store has drained.
//
// Ports:
//   clk_i, rsn_i        clock, synchronous active-low reset
//   req_store_i         enqueue the store described by addr_i/data_i/type
//   req_load_i          forwarding lookup for the load at addr_i/type
//   flush_chance_i      dcache free: the head entry may drain this cycle
//   addr_i              store/load byte address
//   data_i              store data, right-aligned
//   memop_data_type_i   access size (BYTE/HALF/WORD)
//   hit_o, miss_o,      lookup result; exactly one is high during a load
//   trouble_o
//   ld_data_o           forwarded load data, right-aligned, zero-extended
//   full_o              buffer holds NUM_ELEMS stores
//   data_valid_o        head entry is being drained this cycle
//   addr_o, data_o,     drained store, all zero when nothing drains
//   memop_data_type_o
// ---------------------------------------------------------------------------
module segre_store_buffer #(
  parameter int NUM_ELEMS = 2,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 req_store_i,
  input  logic                 req_load_i,
  input  logic                 flush_chance_i,
  input  logic [ADDR_SIZE-1:0] addr_i,
  input  logic [WORD_SIZE-1:0] data_i,
  input  logic [1:0]           memop_data_type_i,
  output logic                 hit_o,
  output logic                 miss_o,
  output logic                 trouble_o,
  output logic [WORD_SIZE-1:0] ld_data_o,
  output logic                 full_o,
  output logic                 data_valid_o,
  output logic [ADDR_SIZE-1:0] addr_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic [1:0]           memop_data_type_o
);

  localparam int PTR_W = $clog2(NUM_ELEMS);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] TYPE_BYTE = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] byte_mask(input logic [1:0] mtype, input logic [1:0] off);
    logic [3:0] m;
    case (mtype)
      TYPE_BYTE: m = 4'b0001 << off;
      TYPE_HALF: m = 4'b0011 << off;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  // Keeps only the low bytes that belong to a load of the given size.
  function automatic logic [WORD_SIZE-1:0] width_mask(input logic [1:0] mtype);
    logic [WORD_SIZE-1:0] m;
    case (mtype)
      TYPE_BYTE: m = WORD_SIZE'(8'hFF);
      TYPE_HALF: m = WORD_SIZE'(16'hFFFF);
      default:   m = '1;
    endcase
    return m;
  endfunction

  logic [NUM_ELEMS-1:0] valid_q;
  logic [ADDR_SIZE-1:0] addr_q [NUM_ELEMS];
  logic [WORD_SIZE-1:0] data_q [NUM_ELEMS];
  logic [1:0]           type_q [NUM_ELEMS];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 drain;
  logic                 push;
  logic [3:0]           ld_mask;
  logic                 found;
  logic [PTR_W-1:0]     found_idx;
  logic [PTR_W-1:0]     idx;
  logic [3:0]           ent_mask;
  logic [1:0]           shift_bytes;
  logic                 covered;

  assign full_o = (count_q == CNT_W'(NUM_ELEMS));

  // A reset cycle must not hand a store to the dcache; the entries are being
  // discarded on the same edge.
  assign drain = rsn_i & flush_chance_i & (count_q != '0);

  // When full, a store is still accepted if the head frees its slot on the
  // same edge.
  assign push = req_store_i & (~full_o | drain);

  assign data_valid_o      = drain;
  assign addr_o            = drain ? addr_q[head_q] : '0;
  assign data_o            = drain ? data_q[head_q] : '0;
  assign memop_data_type_o = drain ? type_q[head_q] : 2'b00;

  // Walk the entries oldest to youngest starting at head.
  // - Valid entries sit contiguously from head, so the last match found is
  //   the youngest overlapping store.
  // - That youngest store decides the lookup result.
  always_comb begin
    ld_mask   = byte_mask(memop_data_type_i, addr_i[1:0]);
    found     = 1'b0;
    found_idx = '0;
    idx       = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] &&
          (addr_q[idx][ADDR_SIZE-1:2] == addr_i[ADDR_SIZE-1:2]) &&
          ((byte_mask(type_q[idx], addr_q[idx][1:0]) & ld_mask) != 4'b0000)) begin
        found     = 1'b1;
        found_idx = idx;
      end
    end
  end

  // A hit needs every load byte inside the chosen store.
  // - The store data is right-aligned at the store address.
  // - Shifting by the byte distance between the two addresses lines the
  //   load bytes up at bit 0.
  always_comb begin
    ent_mask    = byte_mask(type_q[found_idx], addr_q[found_idx][1:0]);
    covered     = ((ld_mask & ~ent_mask) == 4'b0000);
    shift_bytes = addr_i[1:0] - addr_q[found_idx][1:0];
    hit_o       = req_load_i & found & covered;
    trouble_o   = req_load_i & found & ~covered;
    miss_o      = req_load_i & ~found;
    ld_data_o   = '0;
    if (hit_o) begin
      ld_data_o = (data_q[found_idx] >> {shift_bytes, 3'b000}) &
                  width_mask(memop_data_type_i);
    end
  end

  // Pointers wrap naturally because NUM_ELEMS is a power of two.
  // Push and pop on the same edge cancel out in the count.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    case ({push, drain})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage.
  // - When full, the head and tail point at the same slot.
  // - The push write comes after the drain invalidate, so a simultaneous
  //   push and pop leaves that slot valid and holding the new store.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
      end
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        addr_q[tail_q]  <= addr_i;
        data_q[tail_q]  <= data_i;
        type_q[tail_q]  <= memop_data_type_i;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_segre_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_segre_store_buffer
//
// Purpose:
//   Directed, self-checking bench for segre_store_buffer. It steps through
//   forwarding hits, misses and partial overlaps, youngest-entry selection,
//   full and drain behaviour with pointer wrap, and reset discarding pending
//   stores. All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_segre_store_buffer;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  logic        clk;
  logic        rsn;
  logic        reqStore;
  logic        reqLoad;
  logic        flushChance;
  logic [31:0] addrIn;
  logic [31:0] dataIn;
  logic [1:0]  typeIn;
  logic        hit;
  logic        miss;
  logic        trouble;
  logic [31:0] ldData;
  logic        full;
  logic        dataValid;
  logic [31:0] addrOut;
  logic [31:0] dataOut;
  logic [1:0]  typeOut;

  int checkCount = 0;
  int errorCount = 0;

  segre_store_buffer #(
    .NUM_ELEMS(2),
    .ADDR_SIZE(32),
    .WORD_SIZE(32)
  ) dut (
    .clk_i            (clk),
    .rsn_i            (rsn),
    .req_store_i      (reqStore),
    .req_load_i       (reqLoad),
    .flush_chance_i   (flushChance),
    .addr_i           (addrIn),
    .data_i           (dataIn),
    .memop_data_type_i(typeIn),
    .hit_o            (hit),
    .miss_o           (miss),
    .trouble_o        (trouble),
    .ld_data_o        (ldData),
    .full_o           (full),
    .data_valid_o     (dataValid),
    .addr_o           (addrOut),
    .data_o           (dataOut),
    .memop_data_type_o(typeOut)
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one cycle's worth of inputs, then lets the combinational outputs
  // settle well before the next rising edge.
  task automatic applyStimulus(input logic st, input logic ld, input logic fl,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] t);
    reqStore    = st;
    reqLoad     = ld;
    flushChance = fl;
    addrIn      = a;
    dataIn      = d;
    typeIn      = t;
    #2;
  endtask

  // Advances to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Directed sequence of stores, loads, drains and resets.
  initial begin
    rsn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, WORD);
    repeat (2) nextCycle();
    rsn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, WORD);

    // Reset state
    checkOutput("rst_full", {31'b0, full}, 32'd0);
    checkOutput("rst_valid", {31'b0, dataValid}, 32'd0);
    checkOutput("rst_hmt", {29'b0, hit, miss, trouble}, 32'd0);
    checkOutput("rst_ldData", ldData, 32'h0);
    checkOutput("rst_addrOut", addrOut, 32'h0);
    checkOutput("rst_dataOut", dataOut, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD);
    checkOutput("rst_flushEmpty", {31'b0, dataValid}, 32'd0);
    nextCycle();

    // Test 1: WORD store, then sub-word forwarding
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF, WORD);
    checkOutput("t1_sameCycleInvisible", {31'b0, dataValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, BYTE);
    checkOutput("t1_hmt", {29'b0, hit, miss, trouble}, 32'b100);
    checkOutput("t1_ldData", ldData, 32'h000000AD);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h102, 32'h0, HALF);
    checkOutput("t1_half_ldData", ldData, 32'h0000DEAD);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h104, 32'h0, WORD);
    checkOutput("t1_otherWord_hmt", {29'b0, hit, miss, trouble}, 32'b010);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD);
    checkOutput("t1_drain_valid", {31'b0, dataValid}, 32'd1);
    checkOutput("t1_drain_addr", addrOut, 32'h100);
    checkOutput("t1_drain_data", dataOut, 32'hDEADBEEF);
    checkOutput("t1_drain_type", {30'b0, typeOut}, {30'b0, WORD});
    nextCycle();

    // Test 2: BYTE store, partial overlap and disjoint byte
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h200, 32'h55, BYTE);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, WORD);
    checkOutput("t2_trouble_hmt", {29'b0, hit, miss, trouble}, 32'b001);
    checkOutput("t2_trouble_ldData", ldData, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h201, 32'h0, BYTE);
    checkOutput("t2_miss_hmt", {29'b0, hit, miss, trouble}, 32'b010);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, BYTE);
    checkOutput("t2_hit_ldData", ldData, 32'h55);
    nextCycle();

    // Test 3: two stores to one word, the youngest is forwarded
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 32'h1, WORD);
    checkOutput("t3_drain_addr", addrOut, 32'h200);
    checkOutput("t3_drain_data", dataOut, 32'h55);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h2, WORD);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, WORD);
    checkOutput("t3_hmt", {29'b0, hit, miss, trouble}, 32'b100);
    checkOutput("t3_youngest", ldData, 32'h2);
    checkOutput("t3_full", {31'b0, full}, 32'd1);
    nextCycle();

    // Test 4: push and pop while full, dropped store, pointer wrap
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 32'h3, WORD);
    checkOutput("t4_pp_valid", {31'b0, dataValid}, 32'd1);
    checkOutput("t4_pp_addr", addrOut, 32'h10);
    checkOutput("t4_pp_data", dataOut, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, WORD);
    checkOutput("t4_fullStays", {31'b0, full}, 32'd1);
    checkOutput("t4_newVisible", ldData, 32'h3);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h30, 32'h9, WORD);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD);
    checkOutput("t4_d1_addr", addrOut, 32'h10);
    checkOutput("t4_d1_data", dataOut, 32'h2);
    nextCycle();
    checkOutput("t4_notFull", {31'b0, full}, 32'd0);
    checkOutput("t4_d2_addr", addrOut, 32'h20);
    checkOutput("t4_d2_data", dataOut, 32'h3);
    nextCycle();
    checkOutput("t4_empty_valid", {31'b0, dataValid}, 32'd0);
    checkOutput("t4_empty_addr", addrOut, 32'h0);
    nextCycle();

    // Test 4b: HALF store at an upper offset
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h302, 32'hBEEF, HALF);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h303, 32'h0, BYTE);
    checkOutput("t4b_offset_ldData", ldData, 32'hBE);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h301, 32'h0, BYTE);
    checkOutput("t4b_miss_hmt", {29'b0, hit, miss, trouble}, 32'b010);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, WORD);
    checkOutput("t4b_trouble_hmt", {29'b0, hit, miss, trouble}, 32'b001);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD);
    checkOutput("t4b_drain_addr", addrOut, 32'h302);
    checkOutput("t4b_drain_type", {30'b0, typeOut}, {30'b0, HALF});
    nextCycle();

    // Test 5: reset discards pending stores
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h100, 32'h7, WORD);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h104, 32'h8, WORD);
    nextCycle();
    checkOutput("t5_fullBefore", {31'b0, full}, 32'd1);
    rsn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD);
    checkOutput("t5_noDrainInReset", {31'b0, dataValid}, 32'd0);
    nextCycle();
    rsn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, WORD);
    checkOutput("t5_full", {31'b0, full}, 32'd0);
    checkOutput("t5_valid", {31'b0, dataValid}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, WORD);
    checkOutput("t5_miss_hmt", {29'b0, hit, miss, trouble}, 32'b010);
    nextCycle();

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, WORD);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
